// File: rtl/spi_link_sched.sv
// Round-robin TX word scheduler and top-bit RX steering for the 16-bit SPI slave channel.
// Optional statistics counters are built only when SPI_LINK_SCHED_STATS_EN is defined.
module spi_link_sched #(
  parameter int              DW        = 16,
  parameter logic [DW-1:0]   IDLE_WORD = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          spi_rd_int,
  input  logic [DW-1:0] spi_rx_word,
  input  logic          spi_wr_int,
  output logic [DW-1:0] spi_tx_word,
  input  logic          req0_valid,
  input  logic [DW-1:0] req0_data,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [DW-1:0] req1_data,
  output logic          req1_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx0_valid,
  output logic          rx1_valid,
  output logic [15:0]   tx_count,
  output logic [15:0]   rx_count,
  output logic [15:0]   idle_count
);

  typedef enum logic {ST_EMPTY, ST_LOADED} state_t;

  state_t        r_state;
  logic          r_ptr;
  logic [DW-1:0] r_tx_word;
  logic [DW-1:0] r_rx_data;
  logic          r_rx0_valid;
  logic          r_rx1_valid;
  logic          r_rd_s1, r_rd_s2, r_rd_s3;
  logic          r_wr_s1, r_wr_s2, r_wr_s3;

  logic w_rd_edge;
  logic w_wr_edge;
  logic w_empty;
  logic w_hs0;
  logic w_hs1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_s1 <= 1'b0;
      r_rd_s2 <= 1'b0;
      r_rd_s3 <= 1'b0;
      r_wr_s1 <= 1'b0;
      r_wr_s2 <= 1'b0;
      r_wr_s3 <= 1'b0;
    end else begin
      r_rd_s1 <= spi_rd_int;
      r_rd_s2 <= r_rd_s1;
      r_rd_s3 <= r_rd_s2;
      r_wr_s1 <= spi_wr_int;
      r_wr_s2 <= r_wr_s1;
      r_wr_s3 <= r_wr_s2;
    end
  end

  assign w_rd_edge = r_rd_s2 & ~r_rd_s3;
  assign w_wr_edge = r_wr_s2 & ~r_wr_s3;
  assign w_empty   = (r_state == ST_EMPTY);

  // The pointer only breaks ties; a lone valid requester is always granted.
  assign req0_ready = ~rst & w_empty & req0_valid & (~r_ptr | ~req1_valid);
  assign req1_ready = ~rst & w_empty & req1_valid & ( r_ptr | ~req0_valid);
  assign w_hs0      = req0_valid & req0_ready;
  assign w_hs1      = req1_valid & req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_EMPTY;
      r_ptr     <= 1'b0;
      r_tx_word <= IDLE_WORD;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_hs0) begin
            r_tx_word <= req0_data;
            r_state   <= ST_LOADED;
            r_ptr     <= 1'b1;
          end else if (w_hs1) begin
            r_tx_word <= req1_data;
            r_state   <= ST_LOADED;
            r_ptr     <= 1'b0;
          end
        end
        ST_LOADED: begin
          if (w_wr_edge) begin
            r_tx_word <= IDLE_WORD;
            r_state   <= ST_EMPTY;
          end
        end
        default: begin
          r_state   <= ST_EMPTY;
          r_tx_word <= IDLE_WORD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_data   <= '0;
      r_rx0_valid <= 1'b0;
      r_rx1_valid <= 1'b0;
    end else begin
      r_rx0_valid <= w_rd_edge & ~spi_rx_word[DW-1];
      r_rx1_valid <= w_rd_edge &  spi_rx_word[DW-1];
      if (w_rd_edge) r_rx_data <= spi_rx_word;
    end
  end

  assign spi_tx_word = r_tx_word;
  assign rx_data     = r_rx_data;
  assign rx0_valid   = r_rx0_valid;
  assign rx1_valid   = r_rx1_valid;

`ifdef SPI_LINK_SCHED_STATS_EN
  logic [15:0] r_tx_count;
  logic [15:0] r_rx_count;
  logic [15:0] r_idle_count;

  // Counters wrap naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_count   <= '0;
      r_rx_count   <= '0;
      r_idle_count <= '0;
    end else begin
      if (w_wr_edge && !w_empty) r_tx_count   <= r_tx_count + 16'd1;
      if (w_wr_edge &&  w_empty) r_idle_count <= r_idle_count + 16'd1;
      if (w_rd_edge)             r_rx_count   <= r_rx_count + 16'd1;
    end
  end

  assign tx_count   = r_tx_count;
  assign rx_count   = r_rx_count;
  assign idle_count = r_idle_count;
`else
  assign tx_count   = 16'd0;
  assign rx_count   = 16'd0;
  assign idle_count = 16'd0;
`endif

endmodule
